tpu_issue_sequencer: RTL
========================

Name: tpu_issue_sequencer

Overview:
Instruction issue sequencer for the TPU control path. It accepts 32-bit instructions over a valid/ready stream, decodes them, and checks structural and data hazards against busy scoreboards for the systolic array and the VPU. It then issues single-cycle start pulses to the systolic array, the weight FIFO and the VPU. SYNC drains all units and toggles the weight and accumulator double-buffer selects; HALT parks the sequencer.

Parameters:
OPCODE_WIDTH, 6, opcode field width (instr[31:26])
CNT_W, 16, width of the issued-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
instr_valid  in  1  instruction stream valid
instr_data  in  32  [31:26] opcode, [25:24] flags, [23:16] arg1, [15:8] arg2, [7:0] arg3
instr_ready  out  1  sequencer can accept an instruction
sys_start  out  1  one-cycle systolic array start pulse
sys_rows  out  8  row count for MATMUL, valid with sys_start
ub_rd_addr  out  8  unified-buffer read address, valid with sys_start
sys_done  in  1  one-cycle pulse: systolic operation finished
wt_fifo_wr  out  1  one-cycle weight FIFO write pulse
wt_fifo_full  in  1  weight FIFO full
vpu_start  out  1  one-cycle VPU start pulse
vpu_mode  out  4  VPU mode, valid with vpu_start (RELU = 4'h1)
vpu_done  in  1  one-cycle pulse: VPU operation finished
wt_buf_sel  out  1  weight double-buffer select
acc_buf_sel  out  1  accumulator double-buffer select
pipeline_stall  out  1  issue blocked this cycle (combinational)
current_stage  out  2  FSM state encoding
halted  out  1  sequencer in HALT
issued_count  out  CNT_W  count of issued non-NOP instructions, wraps

Behaviour:
- Reset (async, rst_n=0): state FETCH; all pulses, sys_rows, ub_rd_addr, vpu_mode = 0; wt_buf_sel = acc_buf_sel = 0; scoreboards cleared; issued_count = 0; halted = 0. Reset mid-operation drops any latched instruction and busy bits immediately.
- Opcodes: 00 NOP, 01 MATMUL, 02 RD_WEIGHT, 03 RELU, 04 SYNC, 05 HALT. Every other opcode is treated as NOP.
- States and current_stage encoding: FETCH=00, ISSUE=01, DRAIN=10, HALT=11.
- FETCH:
  - instr_ready=1.
  - On instr_valid & instr_ready, latch instr_data into IR and go to ISSUE.
- ISSUE (instr_ready=0): evaluate the hazard for IR.
  - MATMUL: hazard if sys_busy.
  - RD_WEIGHT: hazard if wt_fifo_full.
  - RELU: hazard if vpu_busy or sys_busy (RAW on accumulators).
  - NOP: no hazard; go to FETCH with no pulse.
  - SYNC: go to DRAIN.
  - HALT: go to HALT.
  - Hazard present: stay in ISSUE with pipeline_stall=1.
  - Hazard clear: at the clock edge, register the pulse (high for exactly the next cycle), increment issued_count, go to FETCH.
  - Throughput is at most one instruction per 2 cycles.
- Issue values:
  - MATMUL: sys_start=1, sys_rows=arg3, ub_rd_addr=arg1; sets sys_busy.
  - MATMUL with arg3==0: treated as NOP (no pulse, not counted).
  - RD_WEIGHT: wt_fifo_wr=1.
  - RELU: vpu_start=1, vpu_mode=4'h1; sets vpu_busy.
  - sys_rows, ub_rd_addr and vpu_mode return to 0 when their pulse deasserts.
- Scoreboards:
  - sys_done clears sys_busy; vpu_done clears vpu_busy.
  - A done arriving while not busy is ignored.
  - A done in the same cycle as the hazard check clears busy only at the edge, so the instruction issues one cycle later.
- DRAIN:
  - pipeline_stall=1 while sys_busy | vpu_busy.
  - When both are clear, at that edge toggle wt_buf_sel and acc_buf_sel, increment issued_count, go to FETCH.
  - The toggles are registered and take effect one cycle after the drain condition is met.
- HALT:
  - halted=1, instr_ready=0.
  - Remains until reset. Busy bits still clear on done pulses.
- issued_count wraps from 2^CNT_W-1 to 0; NOPs are not counted.
- At most one pulse output is high in any cycle.

Test Plan:
- Reset with rst_n low -> all outputs 0, current_stage=00, instr_ready=1; after release, async assertion mid-ISSUE clears state immediately.
- MATMUL arg1=8'h10, arg3=8'h08 -> sys_start high 1 cycle, sys_rows=8, ub_rd_addr=0x10; issued_count=1.
- Second MATMUL issued before sys_done -> pipeline_stall=1 in ISSUE; sys_done pulse -> sys_start exactly 1 cycle after the done edge.
- RD_WEIGHT with wt_fifo_full=1 for 5 cycles -> no wt_fifo_wr during those cycles; single pulse after full drops.
- RELU, then SYNC with vpu_done delayed 10 cycles -> stage 10 during the wait; wt_buf_sel and acc_buf_sel both go 0->1 after vpu_done; a second SYNC returns them to 0.
- MATMUL arg3=0, opcode 0x3F, then HALT -> no pulses; issued_count unchanged by the first two; halted=1, instr_ready=0 held.

Source files
------------

// File: rtl/tpu_issue_sequencer.sv
// rtl/tpu_issue_sequencer.sv - TPU instruction issue sequencer with hazard scoreboards
module tpu_issue_sequencer #(
  parameter int OPCODE_WIDTH = 6,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [31:0]      instr_data,
  output logic             instr_ready,
  output logic             sys_start,
  output logic [7:0]       sys_rows,
  output logic [7:0]       ub_rd_addr,
  input  logic             sys_done,
  output logic             wt_fifo_wr,
  input  logic             wt_fifo_full,
  output logic             vpu_start,
  output logic [3:0]       vpu_mode,
  input  logic             vpu_done,
  output logic             wt_buf_sel,
  output logic             acc_buf_sel,
  output logic             pipeline_stall,
  output logic [1:0]       current_stage,
  output logic             halted,
  output logic [CNT_W-1:0] issued_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_ISSUE = 2'b01,
    S_DRAIN = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_MATMUL    = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_RD_WEIGHT = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_RELU      = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_SYNC      = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT      = OPCODE_WIDTH'(5);
  localparam logic [3:0]              MODE_RELU    = 4'h1;

  state_t                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] op_q, op_d;
  logic [7:0]              arg1_q, arg1_d;
  logic [7:0]              arg3_q, arg3_d;
  logic                    sys_busy_q, sys_busy_d;
  logic                    vpu_busy_q, vpu_busy_d;
  logic                    sys_start_q, sys_start_d;
  logic [7:0]              sys_rows_q, sys_rows_d;
  logic [7:0]              ub_rd_addr_q, ub_rd_addr_d;
  logic                    wt_fifo_wr_q, wt_fifo_wr_d;
  logic                    vpu_start_q, vpu_start_d;
  logic [3:0]              vpu_mode_q, vpu_mode_d;
  logic                    wt_buf_sel_q, wt_buf_sel_d;
  logic                    acc_buf_sel_q, acc_buf_sel_d;
  logic [CNT_W-1:0]        issued_count_q, issued_count_d;

  // Flags and arg2 are not consumed by any supported opcode.
  logic unused_fields;
  assign unused_fields = &{instr_data[25:24], instr_data[15:8]};

  // Decode, hazard check, pulse generation and scoreboard update.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    arg1_d         = arg1_q;
    arg3_d         = arg3_q;
    sys_busy_d     = sys_busy_q & ~sys_done;
    vpu_busy_d     = vpu_busy_q & ~vpu_done;
    sys_start_d    = 1'b0;
    sys_rows_d     = 8'h00;
    ub_rd_addr_d   = 8'h00;
    wt_fifo_wr_d   = 1'b0;
    vpu_start_d    = 1'b0;
    vpu_mode_d     = 4'h0;
    wt_buf_sel_d   = wt_buf_sel_q;
    acc_buf_sel_d  = acc_buf_sel_q;
    issued_count_d = issued_count_q;
    instr_ready    = 1'b0;
    pipeline_stall = 1'b0;

    case (state_q)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          op_d    = instr_data[31 -: OPCODE_WIDTH];
          arg1_d  = instr_data[23:16];
          arg3_d  = instr_data[7:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        case (op_q)
          OP_MATMUL: begin
            if (arg3_q == 8'h00) begin
              state_d = S_FETCH;
            end else if (sys_busy_q) begin
              pipeline_stall = 1'b1;
            end else begin
              sys_start_d    = 1'b1;
              sys_rows_d     = arg3_q;
              ub_rd_addr_d   = arg1_q;
              sys_busy_d     = 1'b1;
              issued_count_d = issued_count_q + CNT_W'(1);
              state_d        = S_FETCH;
            end
          end
          OP_RD_WEIGHT: begin
            if (wt_fifo_full) begin
              pipeline_stall = 1'b1;
            end else begin
              wt_fifo_wr_d   = 1'b1;
              issued_count_d = issued_count_q + CNT_W'(1);
              state_d        = S_FETCH;
            end
          end
          OP_RELU: begin
            // RELU reads accumulators, so it also waits on the array.
            if (vpu_busy_q || sys_busy_q) begin
              pipeline_stall = 1'b1;
            end else begin
              vpu_start_d    = 1'b1;
              vpu_mode_d     = MODE_RELU;
              vpu_busy_d     = 1'b1;
              issued_count_d = issued_count_q + CNT_W'(1);
              state_d        = S_FETCH;
            end
          end
          OP_SYNC: state_d = S_DRAIN;
          OP_HALT: state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_DRAIN: begin
        if (sys_busy_q || vpu_busy_q) begin
          pipeline_stall = 1'b1;
        end else begin
          wt_buf_sel_d   = ~wt_buf_sel_q;
          acc_buf_sel_d  = ~acc_buf_sel_q;
          issued_count_d = issued_count_q + CNT_W'(1);
          state_d        = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  // State, instruction register, scoreboards and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_FETCH;
      op_q           <= '0;
      arg1_q         <= 8'h00;
      arg3_q         <= 8'h00;
      sys_busy_q     <= 1'b0;
      vpu_busy_q     <= 1'b0;
      sys_start_q    <= 1'b0;
      sys_rows_q     <= 8'h00;
      ub_rd_addr_q   <= 8'h00;
      wt_fifo_wr_q   <= 1'b0;
      vpu_start_q    <= 1'b0;
      vpu_mode_q     <= 4'h0;
      wt_buf_sel_q   <= 1'b0;
      acc_buf_sel_q  <= 1'b0;
      issued_count_q <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      arg1_q         <= arg1_d;
      arg3_q         <= arg3_d;
      sys_busy_q     <= sys_busy_d;
      vpu_busy_q     <= vpu_busy_d;
      sys_start_q    <= sys_start_d;
      sys_rows_q     <= sys_rows_d;
      ub_rd_addr_q   <= ub_rd_addr_d;
      wt_fifo_wr_q   <= wt_fifo_wr_d;
      vpu_start_q    <= vpu_start_d;
      vpu_mode_q     <= vpu_mode_d;
      wt_buf_sel_q   <= wt_buf_sel_d;
      acc_buf_sel_q  <= acc_buf_sel_d;
      issued_count_q <= issued_count_d;
    end
  end

  assign sys_start     = sys_start_q;
  assign sys_rows      = sys_rows_q;
  assign ub_rd_addr    = ub_rd_addr_q;
  assign wt_fifo_wr    = wt_fifo_wr_q;
  assign vpu_start     = vpu_start_q;
  assign vpu_mode      = vpu_mode_q;
  assign wt_buf_sel    = wt_buf_sel_q;
  assign acc_buf_sel   = acc_buf_sel_q;
  assign issued_count  = issued_count_q;
  assign current_stage = state_q;
  assign halted        = (state_q == S_HALT);

endmodule
